// File: rtl/gpr_wr_arb.sv
// Register-file write arbiter: pipeline writeback has fixed priority, long-latency results queue in a 2-entry FIFO (1-cycle min, 0 with GPR_ARB_BYPASS_EN).
// Backpressure only on the lu side via lu_ready (FIFO full); the pipeline is never stalled and a younger wb write kills queued entries to the same register.
module gpr_wr_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_a3,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  input  logic [4:0]  pend_a1,
  input  logic [4:0]  pend_a2,
  output logic        pend_hit,
  output logic        gpr_we,
  output logic [4:0]  gpr_a3,
  output logic [31:0] gpr_wd
);

  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0][4:0]  a3_q, a3_d;
  logic [1:0][31:0] wd_q, wd_d;
  logic [1:0]       live_q, live_d;

  logic wb_live, head_live, accept, bypass, pop, enq, enq_live;

  assign wb_live   = wb_we && (wb_a3 != 5'd0);
  assign head_live = (count_q != 2'd0) && live_q[rd_ptr_q];
  assign lu_ready  = (count_q != 2'd2) && !reset;
  assign accept    = lu_valid && lu_ready;

`ifdef GPR_ARB_BYPASS_EN
  assign bypass = accept && (count_q == 2'd0) && !wb_live && (lu_a3 != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Dead heads drain every cycle; live heads wait for a free write port.
  assign pop      = (count_q != 2'd0) && (!live_q[rd_ptr_q] || !wb_live);
  assign enq      = accept && !bypass;
  assign enq_live = (lu_a3 != 5'd0) && !(wb_live && (wb_a3 == lu_a3));

  always_comb begin
    gpr_we = 1'b0;
    gpr_a3 = 5'd0;
    gpr_wd = 32'd0;
    if (wb_live) begin
      gpr_we = 1'b1;
      gpr_a3 = wb_a3;
      gpr_wd = wb_wd;
    end else if (head_live) begin
      gpr_we = 1'b1;
      gpr_a3 = a3_q[rd_ptr_q];
      gpr_wd = wd_q[rd_ptr_q];
    end else if (bypass) begin
      gpr_we = 1'b1;
      gpr_a3 = lu_a3;
      gpr_wd = lu_wd;
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (live_q[i] && (((pend_a1 != 5'd0) && (a3_q[i] == pend_a1)) ||
                        ((pend_a2 != 5'd0) && (a3_q[i] == pend_a2))))
        pend_hit = 1'b1;
    end
  end

  always_comb begin
    a3_d   = a3_q;
    wd_d   = wd_q;
    live_d = live_q;
    // Younger pipeline write to the same register supersedes queued results.
    for (int i = 0; i < 2; i++) begin
      if (wb_live && (a3_q[i] == wb_a3)) live_d[i] = 1'b0;
    end
    if (pop) live_d[rd_ptr_q] = 1'b0;
    if (enq) begin
      a3_d[wr_ptr_q]   = lu_a3;
      wd_d[wr_ptr_q]   = lu_wd;
      live_d[wr_ptr_q] = enq_live;
    end
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ enq;
    count_d  = count_q + {1'b0, enq} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      a3_q     <= '0;
      wd_q     <= '0;
      live_q   <= 2'b00;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      live_q   <= live_d;
    end
  end

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Bench for gpr_wr_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_gpr_wr_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_a3 = 5'd0;
  logic [31:0] wb_wd = 32'd0;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_a3 = 5'd0;
  logic [31:0] lu_wd = 32'd0;
  logic        lu_ready;
  logic [4:0]  pend_a1 = 5'd0;
  logic [4:0]  pend_a2 = 5'd0;
  logic        pend_hit;
  logic        gpr_we;
  logic [4:0]  gpr_a3;
  logic [31:0] gpr_wd;

  gpr_wr_arb dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .lu_valid(lu_valid), .lu_a3(lu_a3), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .pend_a1(pend_a1), .pend_a2(pend_a2), .pend_hit(pend_hit),
    .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        live;
  } ent_t;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] dut_rf [32];
  int          aaaa_writes;
  logic        obs_we, obs_rdy, obs_hit;
  logic [4:0]  obs_a3;
  logic [31:0] obs_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs mid-cycle, compare with the model, advance the model at the edge.
  task automatic step();
    logic wbl, e_rdy, acc, byp, e_we, e_hit, pop;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    @(negedge clk);
    obs_we = gpr_we; obs_a3 = gpr_a3; obs_wd = gpr_wd;
    obs_rdy = lu_ready; obs_hit = pend_hit;
    if (obs_we === 1'b1) begin
      dut_rf[obs_a3] = obs_wd;
      if (obs_a3 == 5'd9 && obs_wd == 32'hAAAA) aaaa_writes++;
    end
    if (reset) q.delete();
    wbl   = wb_we && (wb_a3 != 5'd0);
    e_rdy = !reset && (q.size() < 2);
    acc   = lu_valid && e_rdy;
    byp   = 1'b0;
`ifdef GPR_ARB_BYPASS_EN
    byp   = acc && (q.size() == 0) && !wbl && (lu_a3 != 5'd0);
`endif
    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0;
    if (wbl) begin
      e_we = 1'b1; e_a3 = wb_a3; e_wd = wb_wd;
    end else if (q.size() > 0 && q[0].live) begin
      e_we = 1'b1; e_a3 = q[0].a3; e_wd = q[0].wd;
    end else if (byp) begin
      e_we = 1'b1; e_a3 = lu_a3; e_wd = lu_wd;
    end
    e_hit = 1'b0;
    foreach (q[i])
      if (q[i].live && ((pend_a1 != 0 && q[i].a3 == pend_a1) || (pend_a2 != 0 && q[i].a3 == pend_a2)))
        e_hit = 1'b1;
    chk("gpr_we", {31'd0, obs_we}, {31'd0, e_we});
    chk("lu_ready", {31'd0, obs_rdy}, {31'd0, e_rdy});
    chk("pend_hit", {31'd0, obs_hit}, {31'd0, e_hit});
    if (e_we) begin
      chk("gpr_a3", {27'd0, obs_a3}, {27'd0, e_a3});
      chk("gpr_wd", obs_wd, e_wd);
    end
    if (!reset) begin
      pop = (q.size() > 0) && (!q[0].live || !wbl);
      if (pop) void'(q.pop_front());
      if (wbl) foreach (q[i]) if (q[i].a3 == wb_a3) q[i].live = 1'b0;
      if (acc && !byp)
        q.push_back('{a3: lu_a3, wd: lu_wd, live: (lu_a3 != 0) && !(wbl && wb_a3 == lu_a3)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
    lu_valid = 1'b0; lu_a3 = 5'd0; lu_wd = 32'd0;
    pend_a1 = 5'd0; pend_a2 = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_a3 = a; wb_wd = d;
  endtask

  task automatic lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid = 1'b1; lu_a3 = a; lu_wd = d;
  endtask

  initial begin
    foreach (dut_rf[i]) dut_rf[i] = 32'd0;
    aaaa_writes = 0;
    #1;
    // Reset state
    step();
    chk("rst_lu_ready", {31'd0, obs_rdy}, 32'd0);
    chk("rst_gpr_we", {31'd0, obs_we}, 32'd0);
    chk("rst_pend_hit", {31'd0, obs_hit}, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_lu_ready", {31'd0, obs_rdy}, 32'd1);

    // Single lu result on an idle pipeline
    lu(5'd5, 32'h1234);
    step();
`ifdef GPR_ARB_BYPASS_EN
    chk("lat_c0_we", {31'd0, obs_we}, 32'd1);
    chk("lat_c0_wd", obs_wd, 32'h1234);
`else
    chk("lat_c0_we", {31'd0, obs_we}, 32'd0);
`endif
    idle();
    step();
`ifdef GPR_ARB_BYPASS_EN
    chk("lat_c1_we", {31'd0, obs_we}, 32'd0);
`else
    chk("lat_c1_we", {31'd0, obs_we}, 32'd1);
    chk("lat_c1_a3", {27'd0, obs_a3}, 32'd5);
    chk("lat_c1_wd", obs_wd, 32'h1234);
`endif
    step();
    chk("lat_drained_we", {31'd0, obs_we}, 32'd0);
    chk("lat_drained_rdy", {31'd0, obs_rdy}, 32'd1);

    // Busy pipeline fills the FIFO; results retire in order once it goes idle
    do_reset();
    wb(5'd3, 32'h30); lu(5'd7, 32'h77); step();
    wb(5'd3, 32'h31); lu(5'd8, 32'h88); step();
    wb(5'd3, 32'h32); lu(5'd9, 32'h99); step();
    chk("full_lu_ready", {31'd0, obs_rdy}, 32'd0);
    idle(); wb(5'd3, 32'h33); step();
    idle(); step();
    chk("order_c4_a3", {27'd0, obs_a3}, 32'd7);
    chk("order_c4_wd", obs_wd, 32'h77);
    step();
    chk("order_c5_a3", {27'd0, obs_a3}, 32'd8);
    chk("order_c5_wd", obs_wd, 32'h88);
    step();
    chk("order_c6_we", {31'd0, obs_we}, 32'd0);

    // Younger pipeline write kills the queued result
    do_reset();
    aaaa_writes = 0;
    wb(5'd3, 32'h1); lu(5'd9, 32'hAAAA); step();
    idle(); wb(5'd9, 32'hBBBB); step();
    idle(); step(); step(); step();
    chk("kill_rf_r9", dut_rf[9], 32'hBBBB);
    chk("kill_no_aaaa", aaaa_writes, 32'd0);

    // Pending-write queries
    do_reset();
    wb(5'd3, 32'h2); lu(5'd4, 32'h44); step();
    wb(5'd3, 32'h3); lu(5'd0, 32'h55); pend_a1 = 5'd4; pend_a2 = 5'd0; step();
    chk("pend_r4_live", {31'd0, obs_hit}, 32'd1);
    lu_valid = 1'b0; pend_a1 = 5'd0; pend_a2 = 5'd0; step();
    chk("pend_r0_dead", {31'd0, obs_hit}, 32'd0);
    pend_a1 = 5'd5; pend_a2 = 5'd4; step();
    chk("pend_a2_r4", {31'd0, obs_hit}, 32'd1);
    idle(); step(); step(); step();

    // Reset with two results queued
    do_reset();
    wb(5'd3, 32'h4); lu(5'd10, 32'hA0); step();
    wb(5'd3, 32'h5); lu(5'd11, 32'hB0); step();
    idle(); reset = 1'b1; step();
    chk("midrst_we", {31'd0, obs_we}, 32'd0);
    chk("midrst_rdy", {31'd0, obs_rdy}, 32'd0);
    reset = 1'b0; step();
    chk("rel_rdy", {31'd0, obs_rdy}, 32'd1);
    chk("rel_we", {31'd0, obs_we}, 32'd0);
    step();
    chk("rel_we2", {31'd0, obs_we}, 32'd0);

    // Random traffic with a small register range to force collisions
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 79) == 0);
      wb_we    = ($urandom_range(0, 1) == 1);
      wb_a3    = 5'($urandom_range(0, 7));
      wb_wd    = $urandom;
      lu_valid = ($urandom_range(0, 9) < 6);
      lu_a3    = 5'($urandom_range(0, 7));
      lu_wd    = $urandom;
      pend_a1  = 5'($urandom_range(0, 7));
      pend_a2  = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle();
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arb.md
GPR_WR_ARB -- requirements
Module: gpr_wr_arb

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock.
REQ-002 SHALL: reset  in  1  asynchronous, active-high.
REQ-003 SHALL: wb_we  in  1  pipeline writeback request.
REQ-004 SHALL: wb_a3  in  5  pipeline destination register.
REQ-005 SHALL: wb_wd  in  32  pipeline write data.
REQ-006 SHALL: lu_valid  in  1  long-latency unit (mul/div, late load) result valid.
REQ-007 SHALL: lu_a3  in  5  long-latency destination register.
REQ-008 SHALL: lu_wd  in  32  long-latency write data.
REQ-009 SHALL: lu_ready  out  1  long-latency result accepted this cycle when lu_valid=1.
REQ-010 SHALL: pend_a1, pend_a2  in  5 each  decode-stage source register queries.
REQ-011 SHALL: pend_hit  out  1  a queried source has a live queued write.
REQ-012 SHALL: gpr_we, gpr_a3, gpr_wd  out  1/5/32  register-file write port, combinational from inputs and state.

Function
REQ-013 SHALL: hold long-latency results in a 2-entry in-order FIFO; each entry holds a3, wd, live bit; 2-bit count 0..2, 1-bit rd/wr pointers wrapping 1->0.
REQ-014 SHALL: lu_ready = (count != 2) and not reset; full-FIFO simultaneous dequeue does not raise lu_ready in that cycle.
REQ-015 SHALL: fixed priority: live wb write (wb_we=1, wb_a3!=0) always drives the port: gpr_we=1, gpr_a3=wb_a3, gpr_wd=wb_wd; the pipeline is never stalled.
REQ-016 SHALL: when no live wb write, a live FIFO head drives the port and pops at the clock edge.
REQ-017 SHALL: a dead (killed) head pops every cycle it is at the head, regardless of pipeline activity, without asserting gpr_we from it.
REQ-018 SHALL: a live wb write to register R kills every queued entry with a3=R at that edge (younger pipeline write wins).
REQ-019 SHALL: an lu result accepted in the same cycle as a live wb write to the same register is enqueued dead; lu_a3=0 results are accepted and enqueued dead.
REQ-020 SHALL: wb_we=1 with wb_a3=0 counts as idle: gpr_we=0 from pipeline, FIFO may drain.
REQ-021 SHALL: simultaneous enqueue and pop leave count unchanged; enqueue at count=1 with head pop behaves as one-entry queue.
REQ-022 SHALL: pend_hit = 1 iff any live entry has a3 equal to a non-zero pend_a1 or pend_a2; a matching head being written this cycle still reports hit.
REQ-023 SHALL: minimum latency from lu acceptance to gpr_we is 1 cycle without bypass; entries retire strictly in acceptance order.

Reset
REQ-024 SHALL: reset clears count, pointers and all live bits immediately; gpr_we from FIFO=0, pend_hit=0, lu_ready=0 while asserted, 1 in first cycle after release.
REQ-025 SHALL: reset mid-operation discards all queued results without any register-file write.

Configuration
REQ-026 SHALL: macro GPR_ARB_BYPASS_EN defined: when count=0 and no live wb write, a valid live lu result (lu_a3!=0) drives the port in its acceptance cycle and is not enqueued (latency 0).
REQ-027 SHALL: GPR_ARB_BYPASS_EN undefined: every accepted lu result is enqueued; behaviour per REQ-023.

Verification
REQ-028 SHALL: idle pipeline, lu r5=0x1234 at cycle 0 -> gpr_we r5=0x1234 at cycle 1 (cycle 0 with bypass), count back to 0.
REQ-029 SHALL: wb writing r3 cycles 0-3, lu r7/r8 accepted cycles 0-1 -> lu_ready=0 cycle 2, r7 then r8 written cycles 4,5.
REQ-030 SHALL: queued r9=0xAAAA, wb r9=0xBBBB -> entry killed, r9 ends 0xBBBB, no later write of 0xAAAA.
REQ-031 SHALL: queued r4 live, pend_a1=4 -> pend_hit=1; pend_a2=0 with queued r0 dead -> pend_hit=0.
REQ-032 SHALL: two entries queued, reset pulse -> no gpr_we, lu_ready=1 and count=0 after release.
